// File: rtl/key_ctrl.sv
// Hex keypad controller: synchronizes 16 raw key lines, debounces press and release, shifts accepted digits into a 32-bit entry register.
// Latency: key_pulse rises DB_CYCLES+3 edges after a stable raw press is first sampled.
// No backpressure: key_pulse is a one-cycle strobe per accepted press; clr wipes the entry register at the next edge.
module key_ctrl #(
  parameter int DB_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] keys,
  input  logic        clr,
  output logic        key_pulse,
  output logic [3:0]  key_val,
  output logic [31:0] data,
  output logic        busy
);

  localparam logic [15:0] CNT_MAX = 16'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DB_PRESS = 2'd1,
    PRESSED  = 2'd2,
    DB_REL   = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] sync_q1;
  logic [15:0] ks;
  logic [15:0] snap;
  logic [15:0] cnt;

  // Priority encode: index of the highest set bit wins.
  function automatic logic [3:0] enc(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Two-flop synchronizer for the asynchronous key lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 16'h0;
      ks      <= 16'h0;
    end else begin
      sync_q1 <= keys;
      ks      <= sync_q1;
    end
  end

  // Debounce FSM with registered strobe, key value, entry register and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      snap      <= 16'h0;
      cnt       <= 16'h0;
      key_pulse <= 1'b0;
      key_val   <= 4'h0;
      data      <= 32'h0;
      busy      <= 1'b0;
    end else begin
      key_pulse <= 1'b0;
      if (clr) data <= 32'h0;
      case (state)
        IDLE: begin
          if (ks != 16'h0) begin
            state <= DB_PRESS;
            snap  <= ks;
            cnt   <= 16'h0;
            busy  <= 1'b1;
          end
        end
        DB_PRESS: begin
          if (ks == 16'h0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (ks != snap) begin
            // A different key combination restarts the debounce window.
            snap <= ks;
            cnt  <= 16'h0;
          end else if (cnt == CNT_MAX) begin
            state     <= PRESSED;
            key_pulse <= 1'b1;
            key_val   <= enc(snap);
            // Clear takes effect before the shift when both land together.
            data      <= clr ? {28'h0, enc(snap)} : {data[27:0], enc(snap)};
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        PRESSED: begin
          // Roll-over or extra keys are ignored; only a full release matters.
          if (ks == 16'h0) begin
            state <= DB_REL;
            cnt   <= 16'h0;
          end
        end
        DB_REL: begin
          if (ks != 16'h0) begin
            state <= PRESSED;
          end else if (cnt == CNT_MAX) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_ctrl.sv
// Bench for key_ctrl: directed keypad scenarios then randomized key traffic, checked every cycle against a run-length model.
// Model view: a press is accepted once DB_CYCLES+1 identical nonzero samples are seen while armed; re-arm after DB_CYCLES+1 zero samples.
// Inputs are driven on the falling edge; outputs are compared 1 ns after each rising edge.
module tb_key_ctrl;

  localparam int DB = 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] keys;
  logic        clr;
  logic        key_pulse;
  logic [3:0]  key_val;
  logic [31:0] data;
  logic        busy;

  key_ctrl #(.DB_CYCLES(DB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .keys      (keys),
    .clr       (clr),
    .key_pulse (key_pulse),
    .key_val   (key_val),
    .data      (data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // model state
  logic [15:0] p1, p2, last_s;
  int          vrun, zrun;
  bit          armed;
  bit          m_pulse;
  logic [3:0]  m_val;
  logic [31:0] m_data;
  bit          m_busy;

  // observation bookkeeping
  int cyc            = 0;
  int dut_pulses     = 0;
  int last_pulse_cyc = -1;

  function automatic logic [3:0] hexof(input logic [15:0] v);
    logic [3:0] r;
    r = 4'h0;
    for (int i = 0; i < 16; i++) if (v[i]) r = 4'(i);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model step on each rising edge, then compare all outputs just after it.
  always begin
    logic [15:0] s;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      p1 = 0; p2 = 0; last_s = 0; vrun = 0; zrun = 0; armed = 1;
      m_pulse = 0; m_val = 0; m_data = 0; m_busy = 0;
    end else begin
      s  = p2;
      p2 = p1;
      p1 = keys;
      m_pulse = 0;
      if (clr) m_data = 32'h0;
      if (armed) begin
        if (s == 0) vrun = 0;
        else if (s == last_s) vrun++;
        else vrun = 1;
        if (vrun == DB + 1) begin
          m_pulse = 1;
          m_val   = hexof(s);
          m_data  = {m_data[27:0], m_val};
          armed   = 0;
          zrun    = 0;
          vrun    = 0;
        end
      end else begin
        zrun = (s == 0) ? zrun + 1 : 0;
        if (zrun == DB + 1) armed = 1;
      end
      last_s = s;
      m_busy = !armed || (s != 0);
    end
    #1;
    chk("key_pulse", 64'(key_pulse), 64'(m_pulse));
    chk("key_val",   64'(key_val),   64'(m_val));
    chk("data",      64'(data),      64'(m_data));
    chk("busy",      64'(busy),      64'(m_busy));
    if (key_pulse) begin
      dut_pulses++;
      last_pulse_cyc = cyc;
    end
  end

  task automatic hold(input logic [15:0] k, input int n);
    keys = k;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int start, p0, r;
    logic [15:0] k;
    rst_n = 1'b0; keys = 16'h0; clr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // idle after reset
    hold(16'h0, 10);
    chk("idle_pulses", 64'(dut_pulses), 64'd0);
    chk("idle_data", 64'(data), 64'h0);

    // single press of key 5
    p0 = dut_pulses; start = cyc + 1;
    hold(16'h0020, 20);
    hold(16'h0000, 8);
    chk("k5_pulses", 64'(dut_pulses - p0), 64'd1);
    chk("k5_latency", 64'(last_pulse_cyc - start + 1), 64'd7);
    chk("k5_val", 64'(key_val), 64'h5);
    chk("k5_data", 64'(data), 64'h00000005);
    chk("k5_busy", 64'(busy), 64'd0);

    // bouncing key 8, then held
    p0 = dut_pulses;
    for (int i = 0; i < 3; i++) begin
      hold(16'h0100, 2);
      hold(16'h0000, 2);
    end
    start = cyc + 1;
    hold(16'h0100, 12);
    chk("bounce_pulses", 64'(dut_pulses - p0), 64'd1);
    chk("bounce_latency", 64'(last_pulse_cyc - start + 1), 64'd7);
    chk("bounce_val", 64'(key_val), 64'h8);
    hold(16'h0000, 10);

    // priority, roll-over and release glitch
    p0 = dut_pulses;
    hold(16'h8001, 10);
    chk("prio_val", 64'(key_val), 64'hF);
    hold(16'h8003, 6);
    hold(16'h0000, 2);
    hold(16'h8003, 1);
    hold(16'h0000, 12);
    chk("rollover_pulses", 64'(dut_pulses - p0), 64'd1);

    // digits 1..9, then A with a coincident clear
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    p0 = dut_pulses;
    for (int d = 1; d <= 9; d++) begin
      hold(16'(1 << d), 8);
      hold(16'h0000, 8);
    end
    chk("seq_data", 64'(data), 64'h23456789);
    chk("seq_pulses", 64'(dut_pulses - p0), 64'd9);
    keys = 16'h0400;
    repeat (6) @(negedge clk);
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    hold(16'h0400, 3);
    hold(16'h0000, 8);
    chk("clr_accept_data", 64'(data), 64'h0000000A);

    // reset mid-debounce with key still held
    p0 = dut_pulses;
    hold(16'h0008, 5);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", 64'(data), 64'h0);
    rst_n = 1'b1;
    start = cyc + 1;
    hold(16'h0008, 10);
    chk("rst_pulses", 64'(dut_pulses - p0), 64'd1);
    chk("rst_latency", 64'(last_pulse_cyc - start + 1), 64'd7);
    hold(16'h0000, 10);

    // randomized traffic
    for (int it = 0; it < 600; it++) begin
      r = $urandom_range(0, 9);
      if (r < 4) k = 16'h0;
      else if (r < 8) k = 16'(1 << $urandom_range(0, 15));
      else k = 16'(1 << $urandom_range(0, 15)) | 16'(1 << $urandom_range(0, 15));
      keys = k;
      if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
      for (int c = 0; c < int'($urandom_range(1, 12)); c++) begin
        clr = ($urandom_range(0, 15) == 0);
        @(negedge clk);
      end
      clr = 1'b0;
      rst_n = 1'b1;
    end
    hold(16'h0000, 10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/key_ctrl.md
KEY_CTRL -- requirements
Module: key_ctrl

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 1000: number of consecutive stable synchronized samples required to accept a press or a release; legal range 1..65535.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port keys, input, 16 bits: raw keypad lines, asynchronous to clk; bit i high means key of hex value i is pressed.
REQ-005 SHALL have port clr, input, 1 bit: synchronous clear of the entry register.
REQ-006 SHALL have port key_pulse, output, 1 bit: one-cycle strobe marking an accepted key press.
REQ-007 SHALL have port key_val, output, 4 bits: hex value of the last accepted key.
REQ-008 SHALL have port data, output, 32 bits: entry register holding the hex digits accepted so far.
REQ-009 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-010 SHALL pass keys through a 2-flop synchronizer; every decision uses only the synchronized value, ks.
REQ-011 SHALL encode ks by priority: the value is the index of the highest set bit, so bit 15 gives F and bit 0 gives 0.
REQ-012 SHALL implement four FSM states: IDLE, DB_PRESS, PRESSED and DB_REL.
REQ-013 In IDLE, if ks != 0, SHALL go to DB_PRESS, capture snap = ks and set cnt = 0.
REQ-014 In DB_PRESS, if ks == 0, SHALL return to IDLE with no pulse.
REQ-015 In DB_PRESS, if ks != 0 and ks != snap, SHALL restart: snap = ks, cnt = 0.
REQ-016 In DB_PRESS, if ks == snap and cnt == DB_CYCLES-1, SHALL go to PRESSED.
REQ-017 On entering PRESSED, SHALL in that same edge set key_pulse = 1, key_val = enc(snap) and data = {data[27:0], enc(snap)}.
REQ-018 In DB_PRESS, if ks == snap and cnt < DB_CYCLES-1, SHALL increment cnt.
REQ-019 key_pulse SHALL be high for exactly one cycle per accepted press and low at all other times.
REQ-020 In PRESSED, SHALL ignore any change of ks except ks == 0; then go to DB_REL with cnt = 0. Key roll-over or added keys SHALL NOT produce a second pulse.
REQ-021 In DB_REL, if ks != 0, SHALL go back to PRESSED with no pulse.
REQ-022 In DB_REL, if ks == 0 and cnt == DB_CYCLES-1, SHALL go to IDLE; otherwise it SHALL increment cnt.
REQ-023 cnt SHALL be 16 bits wide and SHALL never wrap, since it is bounded by DB_CYCLES-1.
REQ-024 Latency: with raw keys stable and nonzero from clock edge 1 (the first edge that samples them), key_pulse SHALL be high after edge DB_CYCLES+3 and low after edge DB_CYCLES+4.
REQ-025 data SHALL shift left by 4 bits on each accepted key; the oldest digit (bits 31:28) is discarded.
REQ-026 When clr = 1, data SHALL become 0 at the next edge; key_val and the FSM SHALL be unaffected.
REQ-027 If clr and an acceptance occur in the same cycle, data SHALL become {28'b0, enc(snap)}: the clear applies first, then the shift.

Reset
REQ-028 While rst_n = 0, SHALL immediately force: FSM = IDLE, cnt = 0, snap = 0, synchronizer flops = 0, key_pulse = 0, key_val = 0, data = 0, busy = 0.
REQ-029 A reset asserted mid-debounce or mid-press SHALL discard that press, and no pulse SHALL follow deassertion.
REQ-030 After rst_n deasserts, a key already held SHALL be treated as a new press, with the full REQ-024 latency.

Verification (DB_CYCLES = 4)
REQ-031 Reset release, keys = 0 for 10 cycles -> key_pulse = 0, key_val = 0, data = 0, busy = 0 throughout.
REQ-032 keys = 16'h0020 held 20 cycles, then 0 -> a single key_pulse after edge 7, key_val = 5, data = 32'h00000005, busy = 0 within 8 cycles of release.
REQ-033 keys toggle 0/16'h0100 every 2 cycles for 12 cycles, then held at 16'h0100 -> exactly one pulse, occurring 7 edges after the final stable level begins; key_val = 8.
REQ-034 keys = 16'h8001 -> key_val = F; then keys = 16'h8003 while PRESSED -> no second pulse; 1-cycle release glitch during DB_REL -> no pulse.
REQ-035 Keys 1 through 9 entered in order, each with a full release -> data = 32'h23456789 and 9 pulses; clr pulsed in the same cycle as the next accepted key A -> data = 32'h0000000A.
REQ-036 rst_n driven low during DB_PRESS (cnt = 2) and released with key still held -> no pulse until 7 edges after release; data = 0 before that pulse.
